// File: rtl/spdt_bounce_gen.sv
// -----------------------------------------------------------------------------
// spdt_bounce_gen
//
// Transmit end of a simulated SPDT switch. It drives the active-low NO/NC
// contact lines that feed an SR-latch debouncer. When the commanded throw
// changes, the block produces a break-before-make sequence:
//
//   IDLE -> BREAK (old contact opens, may chatter)
//        -> TRANSIT (both contacts open)
//        -> MAKE (new contact closes, may chatter)
//        -> IDLE
//
// The chatter pattern comes from a free-running 16-bit Galois LFSR. The same
// seed and the same command sequence therefore give the same bounce pattern.
//
// Parameters
//   BOUNCE_CYCLES  : length of the BREAK and MAKE windows, in cycles (>= 1)
//   TRANSIT_CYCLES : length of the both-open gap, in cycles (>= 1)
//   GLITCH_W       : chatter segment length = 1 + LFSR[GLITCH_W-1:0]
//   SEED           : LFSR reset value (0 is replaced by 16'h0001)
//
// Ports
//   CLKIN     in  : clock, rising edge
//   RST       in  : synchronous reset, active-high
//   CMD       in  : commanded throw (1 = NO closed, 0 = NC closed)
//   BOUNCE_EN in  : 1 = chatter inside the bounce windows, 0 = clean edges
//   NO        out : normally-open contact, active-low (0 = closed)
//   NC        out : normally-closed contact, active-low (0 = closed)
//   POS       out : settled throw; updates only on return to IDLE
//   BUSY      out : high from the first BREAK cycle to the last MAKE cycle
//   DONE      out : one-cycle pulse on the cycle IDLE is re-entered
// -----------------------------------------------------------------------------
module spdt_bounce_gen #(
    parameter int          BOUNCE_CYCLES  = 64,
    parameter int          TRANSIT_CYCLES = 16,
    parameter int          GLITCH_W       = 3,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic CLKIN,
    input  logic RST,
    input  logic CMD,
    input  logic BOUNCE_EN,
    output logic NO,
    output logic NC,
    output logic POS,
    output logic BUSY,
    output logic DONE
);

    // -------------------------------------------------------------------------
    // Sizing
    // -------------------------------------------------------------------------
    localparam int MAX_CYCLES = (BOUNCE_CYCLES > TRANSIT_CYCLES) ? BOUNCE_CYCLES
                                                                 : TRANSIT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int SW = GLITCH_W + 1;

    localparam logic [CW-1:0] BOUNCE_LAST  = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TRANSIT_LAST = CW'(TRANSIT_CYCLES - 1);

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Polynomial x^16 + x^14 + x^13 + x^11, right-shifting Galois form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BREAK   = 2'd1,
        S_TRANSIT = 2'd2,
        S_MAKE    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // One Galois step: shift right and fold the taps in when the LSB was 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) begin
            r = r ^ LFSR_TAPS;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // The segment counter counts the LFSR value down to zero, so a segment
    // lasts 1 + LFSR[GLITCH_W-1:0] cycles.
    function automatic logic [SW-1:0] seg_load(input logic [GLITCH_W-1:0] v);
        return {1'b0, v};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] seg_q,   seg_d;
    logic [15:0]   lfsr_q,  lfsr_d;
    logic          no_q,    no_d;
    logic          nc_q,    nc_d;
    logic          pos_q,   pos_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // "old" is the contact that matches the current POS; "new" is the other one.
    logic          old_now;
    logic          new_now;
    logic          old_nx;
    logic          new_nx;
    logic          seg_zero;
    logic [SW-1:0] seg_next;

    assign old_now  = pos_q ? no_q : nc_q;
    assign new_now  = pos_q ? nc_q : no_q;
    assign seg_zero = (seg_q == {SW{1'b0}});

    // The segment counter keeps running even with chatter disabled. This keeps
    // the chatter phase deterministic if BOUNCE_EN is enabled again later.
    assign seg_next = seg_zero ? seg_load(lfsr_q[GLITCH_W-1:0])
                               : (seg_q - SW'(1));

    // Next-state, window/segment counters and contact levels
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        pos_d   = pos_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lfsr_d  = lfsr_step(lfsr_q);
        old_nx  = old_now;
        new_nx  = new_now;
        no_d    = no_q;
        nc_d    = nc_q;

        case (state_q)
            S_IDLE: begin
                old_nx = 1'b0;
                new_nx = 1'b1;
                busy_d = 1'b0;
                if (CMD != pos_q) begin
                    // Release the old contact on the first BREAK cycle.
                    state_d = S_BREAK;
                    old_nx  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = BOUNCE_LAST;
                    seg_d   = seg_load(lfsr_q[GLITCH_W-1:0]);
                end else begin
                    cnt_d   = {CW{1'b0}};
                    seg_d   = {SW{1'b0}};
                end
            end

            S_BREAK: begin
                new_nx = 1'b1;
                busy_d = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    // The old contact always leaves BREAK open, whatever the
                    // chatter phase was.
                    state_d = S_TRANSIT;
                    cnt_d   = TRANSIT_LAST;
                    seg_d   = {SW{1'b0}};
                    old_nx  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    seg_d   = seg_next;
                    if (BOUNCE_EN) begin
                        old_nx = seg_zero ? ~old_now : old_now;
                    end else begin
                        old_nx = 1'b1;
                    end
                end
            end

            S_TRANSIT: begin
                old_nx = 1'b1;
                new_nx = 1'b1;
                busy_d = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_MAKE;
                    cnt_d   = BOUNCE_LAST;
                    seg_d   = seg_load(lfsr_q[GLITCH_W-1:0]);
                    new_nx  = 1'b0;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end

            S_MAKE: begin
                old_nx = 1'b1;
                busy_d = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    // Settle: close the new contact solidly and flip the
                    // reported throw.
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                    seg_d   = {SW{1'b0}};
                    new_nx  = 1'b0;
                    pos_d   = ~pos_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    seg_d   = seg_next;
                    if (BOUNCE_EN) begin
                        new_nx = seg_zero ? ~new_now : new_now;
                    end else begin
                        new_nx = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
                seg_d   = {SW{1'b0}};
                old_nx  = 1'b0;
                new_nx  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Map old/new back to physical contacts using the throw held before
        // this edge.
        if (pos_q) begin
            no_d = old_nx;
            nc_d = new_nx;
        end else begin
            no_d = new_nx;
            nc_d = old_nx;
        end
    end

    // State, LFSR and output registers with synchronous reset
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            seg_q   <= {SW{1'b0}};
            lfsr_q  <= SEED_EFF;
            no_q    <= 1'b1;
            nc_q    <= 1'b0;
            pos_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            lfsr_q  <= lfsr_d;
            no_q    <= no_d;
            nc_q    <= nc_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign NO   = no_q;
    assign NC   = nc_q;
    assign POS  = pos_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_spdt_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_spdt_bounce_gen
//
// Three copies of spdt_bounce_gen share one set of inputs:
//   - default seed 16'hACE1
//   - seed 16'h1234
//   - seed 0 (expected to behave as 16'h0001)
//
// A behavioural model tracks the LFSR of each copy and predicts every NO/NC
// cycle. Outputs are packed as {NO, NC, POS, BUSY, DONE}.
// -----------------------------------------------------------------------------
module tb_spdt_bounce_gen;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd = 1'b0;
    logic en  = 1'b0;

    logic [NI-1:0] no_w;
    logic [NI-1:0] nc_w;
    logic [NI-1:0] pos_w;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_seed [NI];
    logic [15:0] m_lf   [NI];
    logic [15:0] m_pre  [NI];
    logic        pos_m = 1'b0;

    typedef struct {
        logic       rst;
        logic       cmd;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    spdt_bounce_gen #(
        .BOUNCE_CYCLES (64),
        .TRANSIT_CYCLES(16),
        .GLITCH_W      (3),
        .SEED          (16'hACE1)
    ) u_dut (
        .CLKIN    (clk),
        .RST      (rst),
        .CMD      (cmd),
        .BOUNCE_EN(en),
        .NO       (no_w[0]),
        .NC       (nc_w[0]),
        .POS      (pos_w[0]),
        .BUSY     (busy_w[0]),
        .DONE     (done_w[0])
    );

    spdt_bounce_gen #(
        .BOUNCE_CYCLES (64),
        .TRANSIT_CYCLES(16),
        .GLITCH_W      (3),
        .SEED          (16'h1234)
    ) u_s1234 (
        .CLKIN    (clk),
        .RST      (rst),
        .CMD      (cmd),
        .BOUNCE_EN(en),
        .NO       (no_w[1]),
        .NC       (nc_w[1]),
        .POS      (pos_w[1]),
        .BUSY     (busy_w[1]),
        .DONE     (done_w[1])
    );

    spdt_bounce_gen #(
        .BOUNCE_CYCLES (64),
        .TRANSIT_CYCLES(16),
        .GLITCH_W      (3),
        .SEED          (16'h0000)
    ) u_s0 (
        .CLKIN    (clk),
        .RST      (rst),
        .CMD      (cmd),
        .BOUNCE_EN(en),
        .NO       (no_w[2]),
        .NC       (nc_w[2]),
        .POS      (pos_w[2]),
        .BUSY     (busy_w[2]),
        .DONE     (done_w[2])
    );

    // Reference LFSR step: x^16 + x^14 + x^13 + x^11, right-shifting Galois.
    function automatic logic [15:0] step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [4:0] outs(input int i);
        return {no_w[i], nc_w[i], pos_w[i], busy_w[i], done_w[i]};
    endfunction

    // Advance one clock. Track each copy's LFSR, then sample 1 ns after the edge.
    task automatic tick();
        for (int i = 0; i < NI; i++) begin
            m_pre[i] = m_lf[i];
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            m_lf[i] = rst ? m_seed[i] : step(m_lf[i]);
        end
        #1;
    endtask

    task automatic chk(input string nm, input int m, input int i,
                       input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s m=%0d inst=%0d got {NO,NC,POS,BUSY,DONE}=%b want %b",
                     nm, m, i, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int m, input logic [4:0] exp);
        for (int i = 0; i < NI; i++) begin
            chk(nm, m, i, outs(i), exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Break-before-make: NO and NC must never both be closed.
    task automatic chk_inv(input string nm, input int m);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (!no_w[i] && !nc_w[i]) begin
                errors++;
                $display("FAIL %s_overlap m=%0d inst=%0d got NO=0 NC=0 want not both 0",
                         nm, m, i);
            end
        end
    endtask

    // Command a throw change and check every cycle against the model.
    // Sample m is taken just after edge E+m, where edge E sees the new CMD.
    //   en_off_m   : BOUNCE_EN is 0 from edge E+en_off_m onward
    //   cmd_back_m : CMD returns to the old throw at edge E+cmd_back_m
    //   rst_m      : RST is asserted at edge E+rst_m
    task automatic run_transition(input string nm, input bit bounce, input int en_off_m,
                                  input int cmd_back_m, input int rst_m);
        logic       target;
        logic       old_is_nc;
        logic       ex_no;
        logic       ex_nc;
        logic [4:0] exp;
        int         seg  [NI];
        logic       oldv [NI];
        logic       newv [NI];

        target    = ~pos_m;
        old_is_nc = ~pos_m;
        cmd       = target;

        for (int m = 0; m <= 145; m++) begin
            en = bounce && (m < en_off_m);
            if (m == cmd_back_m) begin
                cmd = pos_m;
            end
            if (m == rst_m) begin
                rst = 1'b1;
                cmd = 1'b0;
                tick();
                chk_all({nm, "_rst"}, m, 5'b10000);
                rst = 1'b0;
                tick();
                chk_all({nm, "_post"}, m + 1, 5'b10000);
                pos_m = 1'b0;
                return;
            end

            tick();

            for (int i = 0; i < NI; i++) begin
                if (m == 0) begin
                    oldv[i] = 1'b1;
                    newv[i] = 1'b1;
                    seg[i]  = int'(m_pre[i][2:0]);
                end else if (m < 64) begin
                    newv[i] = 1'b1;
                    if (seg[i] == 0) begin
                        if (en) oldv[i] = ~oldv[i];
                        seg[i] = int'(m_pre[i][2:0]);
                    end else begin
                        seg[i] = seg[i] - 1;
                    end
                    if (!en) oldv[i] = 1'b1;
                end else if (m < 80) begin
                    oldv[i] = 1'b1;
                    newv[i] = 1'b1;
                end else if (m == 80) begin
                    oldv[i] = 1'b1;
                    newv[i] = 1'b0;
                    seg[i]  = int'(m_pre[i][2:0]);
                end else if (m < 144) begin
                    oldv[i] = 1'b1;
                    if (seg[i] == 0) begin
                        if (en) newv[i] = ~newv[i];
                        seg[i] = int'(m_pre[i][2:0]);
                    end else begin
                        seg[i] = seg[i] - 1;
                    end
                    if (!en) newv[i] = 1'b0;
                end else begin
                    oldv[i] = 1'b1;
                    newv[i] = 1'b0;
                end

                if (m <= 144) begin
                    ex_no = old_is_nc ? newv[i] : oldv[i];
                    ex_nc = old_is_nc ? oldv[i] : newv[i];
                    exp   = {ex_no, ex_nc, (m == 144) ? target : pos_m,
                             (m < 144), (m == 144)};
                end else if (cmd != target) begin
                    // A CMD that differs from the new throw starts a fresh BREAK.
                    exp = {1'b1, 1'b1, target, 1'b1, 1'b0};
                end else begin
                    exp = {~target, target, target, 1'b0, 1'b0};
                end
                chk(nm, m, i, outs(i), exp);
            end
            chk_inv(nm, m);
        end
        pos_m = target;
    endtask

    initial begin
        m_seed[0] = 16'hACE1;
        m_seed[1] = 16'h1234;
        m_seed[2] = 16'h0001;
        for (int i = 0; i < NI; i++) begin
            m_lf[i]  = 16'h0000;
            m_pre[i] = 16'h0000;
        end

        // Reset behaviour and LFSR seeding, including the zero-seed substitution.
        rst = 1'b1;
        cmd = 1'b0;
        en  = 1'b0;
        repeat (3) tick();
        chk_all("reset", 0, 5'b10000);
        chk16("lfsr_seed_ace1", u_dut.lfsr_q,   16'hACE1);
        chk16("lfsr_seed_1234", u_s1234.lfsr_q, 16'h1234);
        chk16("lfsr_seed_zero", u_s0.lfsr_q,    16'h0001);
        rst = 1'b0;
        tick();
        chk16("lfsr_step1", u_dut.lfsr_q, 16'hE270);
        chk_all("idle_after_reset", 0, 5'b10000);

        // Directed single-cycle vectors.
        vt[0] = '{1'b1, 1'b0, 1'b0, 5'b10000};
        vt[1] = '{1'b1, 1'b1, 1'b1, 5'b10000};
        vt[2] = '{1'b1, 1'b0, 1'b0, 5'b10000};
        vt[3] = '{1'b0, 1'b0, 1'b0, 5'b10000};
        vt[4] = '{1'b0, 1'b0, 1'b1, 5'b10000};
        vt[5] = '{1'b0, 1'b1, 1'b0, 5'b11010};
        vt[6] = '{1'b0, 1'b0, 1'b0, 5'b11010};
        vt[7] = '{1'b1, 1'b0, 1'b0, 5'b10000};
        vt[8] = '{1'b0, 1'b0, 1'b1, 5'b10000};
        for (int v = 0; v < 9; v++) begin
            rst = vt[v].rst;
            cmd = vt[v].cmd;
            en  = vt[v].en;
            tick();
            chk_all($sformatf("vec%0d", v), v, vt[v].exp);
        end
        rst   = 1'b0;
        pos_m = 1'b0;

        // Multi-cycle transitions.
        run_transition("clean01",        1'b0, 0,    -1, -1);
        run_transition("bounce10",       1'b1, 1000, -1, -1);
        run_transition("bounce01_enoff", 1'b1, 100,  -1, -1);
        run_transition("bounce10_enoff", 1'b1, 30,   -1, -1);

        // CMD flips back during BUSY. The transition still completes, then
        // the pending command starts a new BREAK.
        run_transition("cmdback", 1'b1, 1000, 9, -1);
        rst = 1'b1;
        cmd = 1'b0;
        tick();
        chk_all("cmdback_rst", 0, 5'b10000);
        rst   = 1'b0;
        pos_m = 1'b0;
        tick();
        chk_all("cmdback_idle", 1, 5'b10000);

        // Reset in the middle of MAKE.
        run_transition("rst_make",      1'b1, 1000, -1, 100);
        run_transition("bounce01_again", 1'b1, 1000, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
